// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpu_pkg
// Description : Shared types and constants for the MPU6050 burst reader:
//               FSM state encoding, sensor register map, sample slot indices.
// Revision    : 1.0 - initial release
// ============================================================================
package mpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    // MPU6050 register map entries and bus address
    localparam logic [7:0] c_ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] c_PWR_MGMT_1   = 8'h6B;
    localparam logic [6:0] c_DEV_ADDR     = 7'h68;

    // Sample slots in burst order (each slot = one big-endian byte pair)
    localparam int c_NUM_SAMPLES = 7;
    localparam int c_IDX_ACCEL_X = 0;
    localparam int c_IDX_ACCEL_Y = 1;
    localparam int c_IDX_ACCEL_Z = 2;
    localparam int c_IDX_TEMP    = 3;
    localparam int c_IDX_GYRO_X  = 4;
    localparam int c_IDX_GYRO_Y  = 5;
    localparam int c_IDX_GYRO_Z  = 6;

endpackage
`default_nettype wire

// File: rtl/mpu_burst_reader_sat_counter8.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter8
// Description : 8-bit event counter that sticks at 8'hFF instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);

    // Count enabled events, holding at full scale
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mpu_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : mpu_burst_reader
// Description : On each sample tick, issues a 14-byte burst read of the
//               MPU6050 data registers, assembles the big-endian stream into
//               seven signed samples and publishes them with a one-cycle
//               data_valid pulse. Counts dropped ticks and aborted bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_burst_reader
    import mpu_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = c_DEV_ADDR,
    parameter logic [7:0] START_REG   = c_ACCEL_XOUT_H,
    parameter int         NUM_BYTES   = 14,
    parameter int         TIMEOUT_CYC = 50_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_done,
    input  logic               is_read,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [6:0]         cmd_dev,
    output logic [7:0]         cmd_reg,
    output logic [3:0]         cmd_len,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               rx_last,
    input  logic               rx_err,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic signed [15:0] temp_raw,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               data_valid,
    output logic               busy,
    output logic [7:0]         overrun_cnt,
    output logic [7:0]         err_cnt
);

    localparam int         TCNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);
    localparam logic [3:0] FULL_IDX = 4'(NUM_BYTES);

    state_t              r_state;
    logic                r_cmd_valid;
    logic                r_busy;
    logic                r_data_valid;
    logic [3:0]          r_idx;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [7:0]          r_shadow  [NUM_BYTES];
    logic [15:0]         r_samples [c_NUM_SAMPLES];

    logic [7:0]          w_bytes   [NUM_BYTES];
    logic                w_timeout;
    logic                w_done;
    logic                w_abort;
    logic                w_overrun;

    // Command fields are static for this reader
    assign cmd_dev   = DEV_ADDR;
    assign cmd_reg   = START_REG;
    assign cmd_len   = 4'(NUM_BYTES);
    assign cmd_valid = r_cmd_valid;
    assign busy      = r_busy;
    assign data_valid = r_data_valid;

    assign accel_x  = r_samples[c_IDX_ACCEL_X];
    assign accel_y  = r_samples[c_IDX_ACCEL_Y];
    assign accel_z  = r_samples[c_IDX_ACCEL_Z];
    assign temp_raw = r_samples[c_IDX_TEMP];
    assign gyro_x   = r_samples[c_IDX_GYRO_X];
    assign gyro_y   = r_samples[c_IDX_GYRO_Y];
    assign gyro_z   = r_samples[c_IDX_GYRO_Z];

    assign w_timeout = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

    // A tick seen in any busy state (PUBLISH included) is dropped, never queued
    assign w_overrun = is_read && (r_state != ST_IDLE);

    // Completed buffer as seen on the final-byte cycle: the last byte is
    // taken straight from the bus so publish happens one cycle after it
    always_comb begin
        w_bytes = r_shadow;
        w_bytes[NUM_BYTES-1] = rx_data;
    end

    // Burst completion and abort decisions; rx_err outranks everything,
    // and a good final byte outranks a timeout landing on the same cycle
    always_comb begin
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_CMD: begin
                w_abort = !cmd_ready && w_timeout;
            end
            ST_COLLECT: begin
                w_done  = !rx_err && rx_valid && rx_last && (r_idx == LAST_IDX);
                w_abort = rx_err ||
                          (!w_done && ((rx_valid && (rx_last || (r_idx == FULL_IDX))) ||
                                       w_timeout));
            end
            default: ;
        endcase
    end

    // Burst sequencer: command issue, byte collection and sample publish
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cmd_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_idx        <= 4'd0;
            r_tcnt       <= '0;
            for (int b = 0; b < NUM_BYTES; b++) begin
                r_shadow[b] <= 8'd0;
            end
            for (int k = 0; k < c_NUM_SAMPLES; k++) begin
                r_samples[k] <= 16'd0;
            end
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (is_read && init_done) begin
                        r_state     <= ST_CMD;
                        r_cmd_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_tcnt      <= '0;
                    end
                end
                ST_CMD: begin
                    if (w_abort) begin
                        r_state     <= ST_IDLE;
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (cmd_ready) begin
                        r_state     <= ST_COLLECT;
                        r_cmd_valid <= 1'b0;
                        r_idx       <= 4'd0;
                        r_tcnt      <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_done) begin
                        // Even byte is the high half of each sample
                        for (int k = 0; k < c_NUM_SAMPLES; k++) begin
                            r_samples[k] <= {w_bytes[2*k], w_bytes[2*k+1]};
                        end
                        r_data_valid <= 1'b1;
                        r_state      <= ST_PUBLISH;
                    end else begin
                        if (rx_valid) begin
                            r_shadow[r_idx] <= rx_data;
                            r_idx           <= r_idx + 4'd1;
                        end
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                ST_PUBLISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter8 u_overrun_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_overrun),
        .count (overrun_cnt)
    );

    sat_counter8 u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_abort),
        .count (err_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_mpu_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_burst_reader
// Description : Table-driven bench for mpu_burst_reader plus directed
//               sequences for overrun, timeout, reset and saturation cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_burst_reader;

    localparam int K_OK    = 0;  // 14 bytes, rx_last on the 14th
    localparam int K_ERR   = 1;  // n bytes, then a cycle with rx_err (+rx_valid)
    localparam int K_EARLY = 2;  // n bytes, rx_last on the nth
    localparam int K_LONG  = 3;  // n bytes, never rx_last

    typedef struct {
        int         kind;
        int         n;
        logic [7:0] base;
        int         rdy;
        int         exp_pub;
        logic [7:0] exp_err;
        logic [7:0] exp_base;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_done;
    logic               is_read;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [6:0]         cmd_dev;
    logic [7:0]         cmd_reg;
    logic [3:0]         cmd_len;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_last;
    logic               rx_err;
    logic signed [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;
    logic               data_valid;
    logic               busy;
    logic [7:0]         overrun_cnt;
    logic [7:0]         err_cnt;

    int total = 0;
    int bad   = 0;
    int dv_count = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_count++;
    end

    mpu_burst_reader #(
        .DEV_ADDR    (7'h68),
        .START_REG   (8'h3B),
        .NUM_BYTES   (14),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .is_read     (is_read),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dev     (cmd_dev),
        .cmd_reg     (cmd_reg),
        .cmd_len     (cmd_len),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .rx_err      (rx_err),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .temp_raw    (temp_raw),
        .gyro_x      (gyro_x),
        .gyro_y      (gyro_y),
        .gyro_z      (gyro_z),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .err_cnt     (err_cnt)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        is_read = 1'b1;
        step();
        is_read = 1'b0;
    endtask

    // Burst from base b: byte i = b+i, sample k = {byte 2k, byte 2k+1}
    function automatic logic [15:0] exp_sample(input logic [7:0] b, input int k);
        logic [7:0] hi;
        hi = b + 8'(2 * k);
        return {hi, hi + 8'd1};
    endfunction

    task automatic check_all(input string tag, input logic [7:0] b);
        chk({tag, "_accel_x"},  accel_x,  exp_sample(b, 0));
        chk({tag, "_accel_y"},  accel_y,  exp_sample(b, 1));
        chk({tag, "_accel_z"},  accel_z,  exp_sample(b, 2));
        chk({tag, "_temp_raw"}, temp_raw, exp_sample(b, 3));
        chk({tag, "_gyro_x"},   gyro_x,   exp_sample(b, 4));
        chk({tag, "_gyro_y"},   gyro_y,   exp_sample(b, 5));
        chk({tag, "_gyro_z"},   gyro_z,   exp_sample(b, 6));
    endtask

    // Tick, command stall of rdy cycles, then handshake
    task automatic start_cmd(input int rdy);
        tick();
        chk("busy_after_tick", {15'd0, busy}, 16'd1);
        chk("cmd_valid_up", {15'd0, cmd_valid}, 16'd1);
        chk("cmd_fields", {cmd_len, cmd_reg[3:0], 1'b0, cmd_dev}, {4'd14, 4'hB, 1'b0, 7'h68});
        repeat (rdy) step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("cmd_valid_drop", {15'd0, cmd_valid}, 16'd0);
    endtask

    task automatic send_bytes(input int kind, input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = b + 8'(i);
            rx_last  = ((kind == K_OK) || (kind == K_EARLY)) && (i == n - 1);
            rx_err   = 1'b0;
            step();
        end
        if (kind == K_ERR) begin
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
            rx_last  = (n == 13);
            rx_err   = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        int dv0;
        int n;
        logic [7:0] e0;

        vecs[0] = '{K_OK,    14, 8'h01, 3, 1, 8'd0, 8'h01};
        vecs[1] = '{K_ERR,    6, 8'h21, 0, 0, 8'd1, 8'h01};
        vecs[2] = '{K_OK,    14, 8'h21, 1, 1, 8'd1, 8'h21};
        vecs[3] = '{K_EARLY, 10, 8'h41, 0, 0, 8'd2, 8'h21};
        vecs[4] = '{K_LONG,  15, 8'h61, 2, 0, 8'd3, 8'h21};
        vecs[5] = '{K_ERR,   13, 8'h81, 0, 0, 8'd4, 8'h21};
        vecs[6] = '{K_OK,    14, 8'hF1, 0, 1, 8'd4, 8'hF1};

        rst = 1'b1; init_done = 1'b0; is_read = 1'b0; cmd_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0; rx_err = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_cmd_valid", {15'd0, cmd_valid}, 16'd0);
        chk("rst_data_valid", {15'd0, data_valid}, 16'd0);
        chk("rst_counters", {overrun_cnt, err_cnt}, 16'd0);
        chk("rst_samples", accel_x | accel_y | accel_z | temp_raw | gyro_x | gyro_y | gyro_z, 16'd0);

        // Tick ignored before init completes
        tick();
        step();
        chk("gate_cmd_valid", {15'd0, cmd_valid}, 16'd0);
        chk("gate_busy", {15'd0, busy}, 16'd0);
        chk("gate_counters", {overrun_cnt, err_cnt}, 16'd0);
        init_done = 1'b1;

        // Table of bursts
        for (int v = 0; v < 7; v++) begin
            dv0 = dv_count;
            start_cmd(vecs[v].rdy);
            send_bytes(vecs[v].kind, vecs[v].n, vecs[v].base);
            if (vecs[v].kind == K_OK) chk("dv_latency", {15'd0, data_valid}, 16'd1);
            repeat (3) step();
            chk($sformatf("v%0d_pub", v), 16'(dv_count - dv0), 16'(vecs[v].exp_pub));
            chk($sformatf("v%0d_err", v), {8'd0, err_cnt}, {8'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_busy", v), {15'd0, busy}, 16'd0);
            check_all($sformatf("v%0d", v), vecs[v].exp_base);
        end
        chk("table_overrun", {8'd0, overrun_cnt}, 16'd0);

        // Overrun: three ticks 5 cycles apart while stalled, one in PUBLISH
        dv0 = dv_count;
        tick();
        for (int t = 0; t < 3; t++) begin
            repeat (4) step();
            tick();
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        send_bytes(K_OK, 14, 8'hA1);
        chk("ovr_dv_latency", {15'd0, data_valid}, 16'd1);
        chk("ovr_cnt3", {8'd0, overrun_cnt}, 16'd3);
        tick();
        repeat (3) step();
        chk("ovr_cnt4", {8'd0, overrun_cnt}, 16'd4);
        chk("ovr_pub", 16'(dv_count - dv0), 16'd1);
        chk("ovr_no_queue", {15'd0, cmd_valid}, 16'd0);
        chk("ovr_busy", {15'd0, busy}, 16'd0);
        check_all("ovr", 8'hA1);

        // Timeout with cmd_ready held low
        e0 = err_cnt;
        tick();
        n = 0;
        while (cmd_valid === 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("tmo_cycles", 16'(n), 16'd100);
        step();
        chk("tmo_err", {8'd0, err_cnt}, {8'd0, e0 + 8'd1});
        chk("tmo_busy", {15'd0, busy}, 16'd0);
        check_all("tmo_hold", 8'hA1);

        // Reset mid-collect after 5 bytes
        start_cmd(0);
        send_bytes(K_LONG, 5, 8'h51);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {15'd0, busy}, 16'd0);
        chk("mrst_counters", {overrun_cnt, err_cnt}, 16'd0);
        chk("mrst_samples", accel_x | accel_y | accel_z | temp_raw | gyro_x | gyro_y | gyro_z, 16'd0);
        step();
        chk("mrst_err_stays", {8'd0, err_cnt}, 16'd0);
        dv0 = dv_count;
        start_cmd(0);
        send_bytes(K_OK, 14, 8'h01);
        repeat (2) step();
        chk("mrst_pub", 16'(dv_count - dv0), 16'd1);
        check_all("mrst", 8'h01);

        // Saturation: tick every cycle for 300 cycles
        is_read = 1'b1;
        repeat (300) step();
        is_read = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("sat_idle", {15'd0, busy}, 16'd0);
        chk("sat_overrun", {8'd0, overrun_cnt}, 16'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
